ring_output_scheduler: RTL and testbench
========================================

Name: ring_output_scheduler

Overview:
- Schedules one router output port (CW, CCW or PE) between its two input requesters.
- Owns the port's two virtual-channel output buffers: odd (VC0) and even (VC1).
- Per VC: least-recently-used arbitration, hop-field decrement on capture, buffer full/empty tracking, send/ready handshake to the downstream node.
- Three instances per router, all driven by the router's polarity signal.

Parameters:
- DW, 64, packet width in bits.
- HOP_MSB, 55, MSB of the hop-count field.
- HOP_LSB, 48, LSB of the hop-count field.
- DEC_HOP, 1, 1 = decrement hop field on capture (ring ports); 0 = pass packet unmodified (PE port).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- polarity  in  1  active VC this cycle: 0 = VC0 (odd), 1 = VC1 (even).
- req0_v  in  1  requester 0 has a packet for this port on the active VC.
- req0_d  in  DW  requester 0 packet.
- req0_gnt  out  1  requester 0 packet is captured at this clock edge.
- req1_v  in  1  requester 1 has a packet for this port on the active VC.
- req1_d  in  DW  requester 1 packet.
- req1_gnt  out  1  requester 1 packet is captured at this clock edge.
- so  out  1  send: the active VC buffer holds a packet.
- ro  in  1  downstream ready for the active VC.
- dout  out  DW  active VC buffer contents.
- vc_full  out  2  buffer full flags, bit v = VC v.

Behaviour:
- Per-VC state machine, v in {0,1}: EMPTY <-> FULL. No other states.
- The VC is only evaluated when polarity == v. The inactive VC holds all its state: buffer, full flag and LRU pointer.
- EMPTY, active, any req valid:
  - Grant one requester (rule below).
  - At the edge: buf[v] <= packet with hop field [HOP_MSB:HOP_LSB] decremented modulo 2^(HOP_MSB-HOP_LSB+1). Only when DEC_HOP = 1. All other bits unchanged.
  - Go to FULL.
- EMPTY, active, no req valid: stay EMPTY, no grant.
- FULL, active, ro = 1: go to EMPTY at the edge.
- FULL, active, ro = 0: hold buffer and state indefinitely.
- FULL never grants. There is no same-cycle drain-and-refill. The next capture on that VC happens at its next active cycle, so a VC sustains at most one packet per 4 clocks.
- Arbitration, per VC LRU pointer lru[v]:
  - Only one req valid: that requester wins.
  - Both valid: requester lru[v] wins.
  - After any grant to requester i: lru[v] <= ~i.
  - Reset value of lru = 0 (requester 0 preferred).
- Grant timing:
  - req0_gnt / req1_gnt are combinational from polarity, req*_v, full[polarity] and lru[polarity].
  - At most one grant is high in any cycle.
  - A grant is never high while full[polarity] = 1.
  - Requesters clear their input-full flag on the same edge.
- Hop field: 8-bit wrap applies. Hop 0x00 on a ring port wraps to 0xFF; routing upstream is responsible for never sending 0x00.
- Outputs:
  - so = full[polarity]; dout = buf[polarity]; both combinational muxes.
  - vc_full = {full[1], full[0]}.
- Polarity toggling every cycle is the normal case. Any sequence must work, including polarity held constant.
- Reset, asynchronous active-low, at any time including mid-handshake:
  - full = 2'b00, lru = 2'b00, buf[0] = buf[1] = 0.
  - Therefore so = 0, dout = 0, vc_full = 0, gnts = 0.
  - A packet captured or granted in the reset cycle is discarded.
  - Function resumes on the first rising edge after reset deasserts.
- Input X/undefined while req*_v = 0 must not propagate into the buffer.

Test Plan:
1. Reset then idle.
   - Stimulus: reset low mid-cycle, polarity toggling, no requests.
   - Required: so = 0, dout = 0, vc_full = 00, gnts = 0 immediately (asynchronous), and they stay so after release.
2. Single capture.
   - Stimulus: polarity = 0, req0_v = 1, req0_d = 0x0003_0000_0000_1234, DEC_HOP = 1.
   - Required: req0_gnt = 1 that cycle; next polarity-0 cycle so = 1, dout = 0x0002_0000_0000_1234, vc_full = 01.
3. LRU alternation.
   - Stimulus: both req valid on VC1 for 4 consecutive capture opportunities, ro = 1.
   - Required: grant order req0, req1, req0, req1.
   - Required: VC0 lru unaffected; a later VC0 conflict grants req0.
4. Backpressure.
   - Stimulus: VC0 full, ro = 0 for 10 cycles with req1_v = 1, then ro = 1.
   - Required: no grant while full; dout constant; drain at the ro edge; req1 granted at the next polarity-0 cycle, not the same cycle.
5. VC independence.
   - Stimulus: VC0 stalled (ro = 0 whenever polarity = 0), VC1 traffic flowing (ro = 1 whenever polarity = 1).
   - Required: VC1 captures and drains every 4 clocks; VC0 buffer and vc_full[0] = 1 unchanged.
6. Hop wrap and reset mid-operation.
   - Stimulus: capture hop = 0x00 with DEC_HOP = 1.
   - Required: stored hop = 0xFF.
   - Stimulus: assert reset while both VCs are full.
   - Required: vc_full = 00, so = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/ring_output_scheduler.sv
// Output-port scheduler for one ring router port: two single-entry VC buffers,
// per-VC LRU arbitration between two requesters, and a send/ready drain handshake.
module ring_output_scheduler #(
    parameter int DW      = 64,
    parameter int HOP_MSB = 55,
    parameter int HOP_LSB = 48,
    parameter int DEC_HOP = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          polarity,
    input  logic          req0_v,
    input  logic [DW-1:0] req0_d,
    output logic          req0_gnt,
    input  logic          req1_v,
    input  logic [DW-1:0] req1_d,
    output logic          req1_gnt,
    output logic          so,
    input  logic          ro,
    output logic [DW-1:0] dout,
    output logic [1:0]    vc_full
);

    localparam int HW = HOP_MSB - HOP_LSB + 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } vc_state_t;

    vc_state_t     state_r [2];
    logic [DW-1:0] buf_r   [2];
    logic [1:0]    lru_r;

    logic          act_full_s;
    logic          act_lru_s;
    logic          gnt0_s;
    logic          gnt1_s;
    logic          grant_s;
    logic [DW-1:0] sel_d_s;
    logic [DW-1:0] cap_d_s;

    // Hop field wraps modulo 2^HW; all other packet bits pass through untouched.
    function automatic logic [DW-1:0] hop_dec(input logic [DW-1:0] pkt);
        logic [DW-1:0] res;
        res = pkt;
        res[HOP_MSB:HOP_LSB] = pkt[HOP_MSB:HOP_LSB] - {{(HW-1){1'b0}}, 1'b1};
        return res;
    endfunction

    assign act_full_s = (state_r[polarity] == ST_FULL);
    assign act_lru_s  = lru_r[polarity];
    assign grant_s    = gnt0_s | gnt1_s;

    // LRU arbitration on the active VC; held off while its buffer is full or in reset.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!reset || act_full_s) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (req0_v && req1_v) begin
            if (act_lru_s) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b1;
            end
        end else if (req0_v) begin
            gnt0_s = 1'b1;
        end else if (req1_v) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Capture path: only the granted requester's data reaches the buffer.
    always_comb begin
        sel_d_s = req0_d;
        cap_d_s = req0_d;
        if (gnt1_s) begin
            sel_d_s = req1_d;
        end else begin
            sel_d_s = req0_d;
        end
        if (DEC_HOP != 0) begin
            cap_d_s = hop_dec(sel_d_s);
        end else begin
            cap_d_s = sel_d_s;
        end
    end

    // Per-VC EMPTY/FULL machine; only the VC selected by polarity advances.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r[0] <= ST_EMPTY;
            state_r[1] <= ST_EMPTY;
            buf_r[0]   <= {DW{1'b0}};
            buf_r[1]   <= {DW{1'b0}};
            lru_r      <= 2'b00;
        end else begin
            case (state_r[polarity])
                ST_EMPTY: begin
                    if (grant_s) begin
                        buf_r[polarity]   <= cap_d_s;
                        state_r[polarity] <= ST_FULL;
                        lru_r[polarity]   <= gnt0_s;
                    end
                end
                ST_FULL: begin
                    if (ro) begin
                        state_r[polarity] <= ST_EMPTY;
                    end
                end
                default: begin
                    state_r[polarity] <= ST_EMPTY;
                end
            endcase
        end
    end

    assign req0_gnt = gnt0_s;
    assign req1_gnt = gnt1_s;
    assign so       = act_full_s;
    assign dout     = buf_r[polarity];
    assign vc_full  = {(state_r[1] == ST_FULL), (state_r[0] == ST_FULL)};

endmodule

// File: tb/tb_ring_output_scheduler.sv
// Directed bench for ring_output_scheduler: reset, capture, LRU, backpressure,
// VC independence, hop wrap and asynchronous reset with both VCs full.
module tb_ring_output_scheduler;

    logic        clk;
    logic        reset;
    logic        polarity;
    logic        req0_v;
    logic [63:0] req0_d;
    logic        req0_gnt;
    logic        req1_v;
    logic [63:0] req1_d;
    logic        req1_gnt;
    logic        so;
    logic        ro;
    logic [63:0] dout;
    logic [1:0]  vc_full;

    int checks_r;
    int errors_r;

    ring_output_scheduler #(
        .DW(64), .HOP_MSB(55), .HOP_LSB(48), .DEC_HOP(1)
    ) dut (
        .clk(clk), .reset(reset), .polarity(polarity),
        .req0_v(req0_v), .req0_d(req0_d), .req0_gnt(req0_gnt),
        .req1_v(req1_v), .req1_d(req1_d), .req1_gnt(req1_gnt),
        .so(so), .ro(ro), .dout(dout), .vc_full(vc_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pol, input logic r0v, input logic [63:0] r0d,
                         input logic r1v, input logic [63:0] r1d, input logic rdy);
        polarity = pol;
        req0_v   = r0v;
        req0_d   = r0d;
        req1_v   = r1v;
        req1_d   = r1d;
        ro       = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // LRU test vectors: grant order and stored packets on VC1
    logic        lru_exp_gnt1 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] lru_exp_dout [4] = '{64'h0004_0000_0000_0A00, 64'h0006_0000_0000_0B00,
                                      64'h0004_0000_0000_0A00, 64'h0006_0000_0000_0B00};
    // VC-independence vectors on VC1 while VC0 is stalled
    logic [63:0] ind_in  [3] = '{64'hA510_0000_0000_1000, 64'hA511_0000_0000_1001,
                                 64'hA512_0000_0000_1002};
    logic [63:0] ind_exp [3] = '{64'hA50F_0000_0000_1000, 64'hA510_0000_0000_1001,
                                 64'hA511_0000_0000_1002};

    initial begin
        checks_r = 0;
        errors_r = 0;
        reset    = 1'b1;
        drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        tick();
        tick();

        // 1. asynchronous reset mid-cycle, then idle with polarity toggling
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_so", so, 64'h0);
        check_eq("rst_dout", dout, 64'h0);
        check_eq("rst_vc_full", vc_full, 64'h0);
        check_eq("rst_gnt0", req0_gnt, 64'h0);
        check_eq("rst_gnt1", req1_gnt, 64'h0);
        tick();
        drive(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        tick();
        @(negedge clk);
        reset = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(i[0], 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
            check_eq("idle_so", so, 64'h0);
            check_eq("idle_vc_full", vc_full, 64'h0);
            check_eq("idle_gnt", {req0_gnt, req1_gnt}, 64'h0);
            tick();
        end

        // 2. single capture on VC0 with hop decrement
        drive(1'b0, 1'b1, 64'h0003_0000_0000_1234, 1'b0, 64'h0, 1'b0);
        check_eq("cap_gnt0", req0_gnt, 64'h1);
        check_eq("cap_gnt1", req1_gnt, 64'h0);
        tick();
        drive(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        check_eq("cap_vc_full", vc_full, 64'h1);
        check_eq("cap_so_vc1", so, 64'h0);
        tick();
        drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        check_eq("cap_so", so, 64'h1);
        check_eq("cap_dout", dout, 64'h0002_0000_0000_1234);
        tick();

        // 4. backpressure on VC0: no grant while full, drain on ro, regrant later
        for (int i = 0; i < 10; i++) begin
            drive(i[0], 1'b0, 64'h0, ~i[0], 64'h00AA_0000_0000_5555, 1'b0);
            if (!i[0]) begin
                check_eq("bp_gnt", {req0_gnt, req1_gnt}, 64'h0);
                check_eq("bp_dout", dout, 64'h0002_0000_0000_1234);
            end
            tick();
        end
        drive(1'b0, 1'b0, 64'h0, 1'b1, 64'h00AA_0000_0000_5555, 1'b1);
        check_eq("bp_drain_gnt", req1_gnt, 64'h0);
        check_eq("bp_drain_so", so, 64'h1);
        tick();
        drive(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        check_eq("bp_drained", vc_full, 64'h0);
        tick();
        drive(1'b0, 1'b0, 64'h0, 1'b1, 64'h00AA_0000_0000_5555, 1'b0);
        check_eq("bp_regrant", req1_gnt, 64'h1);
        tick();
        drive(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        check_eq("bp_dout2", dout, 64'h00A9_0000_0000_5555);
        tick();

        // 3. LRU alternation on VC1 with both requesters valid
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 64'h0005_0000_0000_0A00, 1'b1, 64'h0007_0000_0000_0B00, 1'b1);
            check_eq("lru_gnt1", req1_gnt, {63'h0, lru_exp_gnt1[k]});
            check_eq("lru_gnt0", req0_gnt, {63'h0, ~lru_exp_gnt1[k]});
            tick();
            drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
            tick();
            drive(1'b1, 1'b1, 64'h0005_0000_0000_0A00, 1'b1, 64'h0007_0000_0000_0B00, 1'b1);
            check_eq("lru_full_nogrant", {req0_gnt, req1_gnt}, 64'h0);
            check_eq("lru_dout", dout, lru_exp_dout[k]);
            tick();
            drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
            tick();
        end
        drive(1'b0, 1'b1, 64'h0020_0000_0000_C0DE, 1'b1, 64'h0030_0000_0000_0BAD, 1'b0);
        check_eq("vc0_lru_gnt0", req0_gnt, 64'h1);
        check_eq("vc0_lru_gnt1", req1_gnt, 64'h0);
        tick();

        // 5. VC0 stalled, VC1 flowing every 4 clocks
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, ind_in[k], 1'b0, 64'h0, 1'b1);
            check_eq("ind_gnt", req0_gnt, 64'h1);
            tick();
            drive(1'b0, 1'b0, 64'h0, 1'b1, 64'h0000_0000_0000_0001, 1'b0);
            check_eq("ind_vc0_gnt", {req0_gnt, req1_gnt}, 64'h0);
            check_eq("ind_vc0_dout", dout, 64'h001F_0000_0000_C0DE);
            check_eq("ind_vc_full", vc_full, 64'h3);
            tick();
            drive(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
            check_eq("ind_vc1_so", so, 64'h1);
            check_eq("ind_vc1_dout", dout, ind_exp[k]);
            tick();
            drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
            check_eq("ind_vc1_drained", vc_full, 64'h1);
            tick();
        end

        // 6. hop wrap 0x00 -> 0xFF, then asynchronous reset with both VCs full
        drive(1'b1, 1'b0, 64'h0, 1'b1, 64'h1200_0000_0000_0055, 1'b0);
        check_eq("wrap_gnt", req1_gnt, 64'h1);
        tick();
        drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        check_eq("wrap_vc_full", vc_full, 64'h3);
        tick();
        drive(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        check_eq("wrap_dout", dout, 64'h12FF_0000_0000_0055);
        #2;
        reset = 1'b0;
        #1;
        check_eq("mid_rst_vc_full", vc_full, 64'h0);
        check_eq("mid_rst_so", so, 64'h0);
        check_eq("mid_rst_dout", dout, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        drive(1'b0, 1'b1, 64'h0009_0000_0000_0001, 1'b1, 64'h0009_0000_0000_0002, 1'b1);
        check_eq("post_rst_lru_gnt0", req0_gnt, 64'h1);
        check_eq("post_rst_lru_gnt1", req1_gnt, 64'h0);
        tick();
        drive(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        check_eq("post_rst_dout", dout, 64'h0008_0000_0000_0001);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule
